// File: rtl/mem_load_sequencer.sv
// Boot/load controller: streams 64-bit beats into instruction then data memory through the
// Datapath external-memory ports, releases the pipeline, and supervises the run until limit or halt.
module mem_load_sequencer #(
  parameter int PC_W       = 9,
  parameter int DM_ADDRESS = 9,
  parameter int INS_W      = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [PC_W-3:0]         inst_beats,
  input  logic [DM_ADDRESS-3:0]   data_beats,
  input  logic [CNT_W-1:0]        run_limit,
  input  logic                    halt,
  input  logic                    src_valid,
  input  logic [63:0]             src_data,
  output logic                    src_ready,
  output logic                    enable_load_ex_mem,
  output logic [PC_W-1:0]         InstExMemAddress,
  output logic [INS_W-1:0]        InstExMemData1,
  output logic [INS_W-1:0]        InstExMemData2,
  output logic [DM_ADDRESS-1:0]   DataExMemAddress,
  output logic [DATA_W-1:0]       DataExMemData1,
  output logic [DATA_W-1:0]       DataExMemData2,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        cycle_count
);

  localparam int BW = ((PC_W > DM_ADDRESS) ? PC_W : DM_ADDRESS) - 2;
  localparam logic [PC_W-3:0]       INST_ONE = 1;
  localparam logic [DM_ADDRESS-3:0] DATA_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_INST, LOAD_DATA, COMMIT, RUN, DONE
  } state_t;

  state_t                  state_q;
  logic [BW-1:0]           beat_q;
  logic [PC_W-3:0]         inst_beats_q;
  logic [DM_ADDRESS-3:0]   data_beats_q;
  logic [CNT_W-1:0]        run_limit_q;
  logic [CNT_W-1:0]        cycle_q;
  logic                    enable_q;
  logic [PC_W-1:0]         inst_addr_q;
  logic [INS_W-1:0]        inst_d1_q, inst_d2_q;
  logic [DM_ADDRESS-1:0]   data_addr_q;
  logic [DATA_W-1:0]       data_d1_q, data_d2_q;

  logic                    hs_d;
  logic                    last_inst_d, last_data_d;
  logic [BW-1:0]           beat_inc_d;
  logic [CNT_W-1:0]        cycle_inc_d;
  logic                    run_end_d;

  always_comb begin
    hs_d        = src_valid & src_ready;
    beat_inc_d  = beat_q + BW'(1);
    last_inst_d = (beat_q == BW'(inst_beats_q - INST_ONE));
    last_data_d = (beat_q == BW'(data_beats_q - DATA_ONE));
    cycle_inc_d = cycle_q + CNT_W'(1);
    // Ending on cycle_q+1 gives exactly run_limit cycles in RUN.
    run_end_d   = halt || ((run_limit_q != '0) && (cycle_inc_d == run_limit_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      inst_beats_q <= '0;
      data_beats_q <= '0;
      run_limit_q  <= '0;
      cycle_q      <= '0;
      enable_q     <= 1'b1;
      inst_addr_q  <= '0;
      inst_d1_q    <= '0;
      inst_d2_q    <= '0;
      data_addr_q  <= '0;
      data_d1_q    <= '0;
      data_d2_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            inst_beats_q <= inst_beats;
            data_beats_q <= data_beats;
            run_limit_q  <= run_limit;
            beat_q       <= '0;
            cycle_q      <= '0;
            enable_q     <= 1'b1;
            if (inst_beats != '0)      state_q <= LOAD_INST;
            else if (data_beats != '0) state_q <= LOAD_DATA;
            else                       state_q <= COMMIT;
          end
        end
        LOAD_INST: begin
          if (hs_d) begin
            // Byte address 8*beat; bits above PC_W are dropped so oversize loads wrap.
            inst_addr_q <= PC_W'({beat_q, 3'b000});
            inst_d1_q   <= INS_W'(src_data[31:0]);
            inst_d2_q   <= INS_W'(src_data[63:32]);
            if (last_inst_d) begin
              beat_q  <= '0;
              state_q <= (data_beats_q != '0) ? LOAD_DATA : COMMIT;
            end else begin
              beat_q  <= beat_inc_d;
            end
          end
        end
        LOAD_DATA: begin
          if (hs_d) begin
            data_addr_q <= DM_ADDRESS'({beat_q, 3'b000});
            data_d1_q   <= DATA_W'(src_data[31:0]);
            data_d2_q   <= DATA_W'(src_data[63:32]);
            if (last_data_d) begin
              beat_q  <= '0;
              state_q <= COMMIT;
            end else begin
              beat_q  <= beat_inc_d;
            end
          end
        end
        COMMIT: begin
          // The final pair is written this cycle; the pipeline leaves reset on the next.
          enable_q <= 1'b0;
          state_q  <= RUN;
        end
        RUN: begin
          cycle_q <= cycle_inc_d;
          if (run_end_d) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_ready          = (state_q == LOAD_INST) || (state_q == LOAD_DATA);
  assign busy               = (state_q == LOAD_INST) || (state_q == LOAD_DATA) ||
                              (state_q == COMMIT)    || (state_q == RUN);
  assign done               = (state_q == DONE);
  assign enable_load_ex_mem = enable_q;
  assign InstExMemAddress   = inst_addr_q;
  assign InstExMemData1     = inst_d1_q;
  assign InstExMemData2     = inst_d2_q;
  assign DataExMemAddress   = data_addr_q;
  assign DataExMemData1     = data_d1_q;
  assign DataExMemData2     = data_d2_q;
  assign cycle_count        = cycle_q;

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Directed bench for mem_load_sequencer: a table of per-cycle vectors for the main load/run
// flows, plus hand-written sequences for valid gaps, address wrap and mid-load reset.
module tb_mem_load_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  inst_beats = '0;
  logic [6:0]  data_beats = '0;
  logic [31:0] run_limit = '0;
  logic        halt = 1'b0;
  logic        src_valid = 1'b0;
  logic [63:0] src_data = '0;
  logic        src_ready, enable_load_ex_mem, busy, done;
  logic [8:0]  InstExMemAddress, DataExMemAddress;
  logic [31:0] InstExMemData1, InstExMemData2, DataExMemData1, DataExMemData2, cycle_count;

  int total = 0;
  int bad   = 0;

  mem_load_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .inst_beats(inst_beats), .data_beats(data_beats),
    .run_limit(run_limit), .halt(halt), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .enable_load_ex_mem(enable_load_ex_mem),
    .InstExMemAddress(InstExMemAddress), .InstExMemData1(InstExMemData1),
    .InstExMemData2(InstExMemData2), .DataExMemAddress(DataExMemAddress),
    .DataExMemData1(DataExMemData1), .DataExMemData2(DataExMemData2),
    .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [6:0]  ib, db;
    logic [31:0] lim;
    logic        hlt, vld;
    logic [63:0] sd;
    logic        en, bsy, dn, rdy;
    logic [8:0]  ia;
    logic [31:0] id1, id2;
    logic [8:0]  da;
    logic [31:0] dd1, dd2, cc;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] A = 64'h11111111_22222222;
  localparam logic [63:0] B = 64'h33333333_44444444;
  localparam logic [63:0] C = 64'h55555555_66666666;
  localparam logic [63:0] D = 64'hDEADBEEF_CAFEF00D;

  function automatic vec_t mk(input logic st, input int ib, input int db, input int lim,
                              input logic hlt, input logic vld, input logic [63:0] sd,
                              input logic en, input logic bsy, input logic dn, input logic rdy,
                              input int ia, input logic [31:0] id1, input logic [31:0] id2,
                              input int da, input logic [31:0] dd1, input logic [31:0] dd2,
                              input int cc);
    vec_t v;
    v.st = st; v.ib = 7'(ib); v.db = 7'(db); v.lim = 32'(lim); v.hlt = hlt; v.vld = vld;
    v.sd = sd; v.en = en; v.bsy = bsy; v.dn = dn; v.rdy = rdy; v.ia = 9'(ia);
    v.id1 = id1; v.id2 = id2; v.da = 9'(da); v.dd1 = dd1; v.dd2 = dd2; v.cc = 32'(cc);
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    start = v.st; inst_beats = v.ib; data_beats = v.db; run_limit = v.lim;
    halt = v.hlt; src_valid = v.vld; src_data = v.sd;
  endtask

  task automatic expect_vec(input string t, input vec_t v);
    check({t, ".en"},   64'(enable_load_ex_mem), 64'(v.en));
    check({t, ".busy"}, 64'(busy),               64'(v.bsy));
    check({t, ".done"}, 64'(done),               64'(v.dn));
    check({t, ".rdy"},  64'(src_ready),          64'(v.rdy));
    check({t, ".ia"},   64'(InstExMemAddress),   64'(v.ia));
    check({t, ".id1"},  64'(InstExMemData1),     64'(v.id1));
    check({t, ".id2"},  64'(InstExMemData2),     64'(v.id2));
    check({t, ".da"},   64'(DataExMemAddress),   64'(v.da));
    check({t, ".dd1"},  64'(DataExMemData1),     64'(v.dd1));
    check({t, ".dd2"},  64'(DataExMemData2),     64'(v.dd2));
    check({t, ".cc"},   64'(cycle_count),        64'(v.cc));
  endtask

  task automatic check_idle(input string t);
    check({t, ".en"},   64'(enable_load_ex_mem), 64'd1);
    check({t, ".busy"}, 64'(busy),               64'd0);
    check({t, ".done"}, 64'(done),               64'd0);
    check({t, ".rdy"},  64'(src_ready),          64'd0);
    check({t, ".ia"},   64'(InstExMemAddress),   64'd0);
    check({t, ".id1"},  64'(InstExMemData1),     64'd0);
    check({t, ".da"},   64'(DataExMemAddress),   64'd0);
    check({t, ".dd2"},  64'(DataExMemData2),     64'd0);
    check({t, ".cc"},   64'(cycle_count),        64'd0);
  endtask

  initial begin
    logic [8:0]  exp_ia;
    logic [31:0] exp_id1;
    int          k;

    // inst=2, data=1, limit=10; beats A,B,C back to back; valid in COMMIT/RUN is ignored
    tbl.push_back(mk(1,2,1,10,0,0,64'd0, 1,1,0,1, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(0,2,1,10,0,1,A,     1,1,0,1, 0,32'h22222222,32'h11111111, 0,0,0, 0));
    tbl.push_back(mk(0,2,1,10,0,1,B,     1,1,0,1, 8,32'h44444444,32'h33333333, 0,0,0, 0));
    tbl.push_back(mk(0,2,1,10,0,1,C,     1,1,0,0, 8,32'h44444444,32'h33333333,
                     0,32'h66666666,32'h55555555, 0));
    tbl.push_back(mk(0,2,1,10,0,1,D,     0,1,0,0, 8,32'h44444444,32'h33333333,
                     0,32'h66666666,32'h55555555, 0));
    for (int i = 1; i <= 9; i++)
      tbl.push_back(mk((i == 2), 0,0,5, 0,(i == 1),D, 0,1,0,0, 8,32'h44444444,32'h33333333,
                       0,32'h66666666,32'h55555555, i));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0,0,0,5,0,0,64'd0, 0,0,1,0, 8,32'h44444444,32'h33333333,
                       0,32'h66666666,32'h55555555, 10));
    // restart from DONE with no beats, limit=3: straight to COMMIT, count cleared
    tbl.push_back(mk(1,0,0,3,0,0,64'd0, 1,1,0,0, 8,32'h44444444,32'h33333333,
                     0,32'h66666666,32'h55555555, 0));
    for (int i = 0; i <= 2; i++)
      tbl.push_back(mk(0,0,0,3,0,0,64'd0, 0,1,0,0, 8,32'h44444444,32'h33333333,
                       0,32'h66666666,32'h55555555, i));
    tbl.push_back(mk(0,0,0,3,0,0,64'd0, 0,0,1,0, 8,32'h44444444,32'h33333333,
                     0,32'h66666666,32'h55555555, 3));
    // unlimited run ended by halt after 7 cycles, then halt coinciding with limit=7
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(1,0,0,(r == 0) ? 0 : 7,0,0,64'd0, 1,1,0,0, 8,32'h44444444,32'h33333333,
                       0,32'h66666666,32'h55555555, 0));
      for (int i = 0; i <= 6; i++)
        tbl.push_back(mk(0,0,0,0,0,0,64'd0, 0,1,0,0, 8,32'h44444444,32'h33333333,
                         0,32'h66666666,32'h55555555, i));
      tbl.push_back(mk(0,0,0,0,1,0,64'd0, 0,0,1,0, 8,32'h44444444,32'h33333333,
                       0,32'h66666666,32'h55555555, 7));
      tbl.push_back(mk(0,0,0,0,0,0,64'd0, 0,0,1,0, 8,32'h44444444,32'h33333333,
                       0,32'h66666666,32'h55555555, 7));
    end

    step();
    check_idle("reset");
    reset = 1'b1;
    step();
    check_idle("idle");

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      step();
      expect_vec($sformatf("v%0d", i), tbl[i]);
    end

    // valid on one cycle in three during LOAD_INST
    start = 1; inst_beats = 3; data_beats = 1; run_limit = 1; src_valid = 0; halt = 0;
    step();
    start = 0;
    exp_ia = 9'd8; exp_id1 = 32'h44444444; k = 0;
    for (int c = 0; c < 9; c++) begin
      src_valid = (c % 3 == 2);
      src_data  = {32'h0, 32'hA000 + 32'(c)};
      step();
      if (c % 3 == 2) begin
        exp_ia  = 9'(8 * k);
        exp_id1 = 32'hA000 + 32'(c);
        k++;
      end
      check($sformatf("gap%0d.ia", c),  64'(InstExMemAddress), 64'(exp_ia));
      check($sformatf("gap%0d.id1", c), 64'(InstExMemData1),   64'(exp_id1));
      check($sformatf("gap%0d.rdy", c), 64'(src_ready),        64'd1);
    end
    src_valid = 1; src_data = 64'h0000F00D_0000BEEF;
    step();
    src_valid = 0;
    check("gap.da",      64'(DataExMemAddress), 64'd0);
    check("gap.dd1",     64'(DataExMemData1),   64'h0000BEEF);
    check("gap.dd2",     64'(DataExMemData2),   64'h0000F00D);
    check("gap.commit",  64'(src_ready),        64'd0);
    step();
    check("gap.run_en",  64'(enable_load_ex_mem), 64'd0);
    step();
    check("gap.done",    64'(done),        64'd1);
    check("gap.cc",      64'(cycle_count), 64'd1);

    // 65 instruction beats into a 64-beat memory: beat 64 wraps to address 0
    start = 1; inst_beats = 65; data_beats = 0; run_limit = 1;
    step();
    start = 0;
    for (int b = 0; b <= 64; b++) begin
      src_valid = 1;
      src_data  = {32'(b), 32'h100 + 32'(b)};
      step();
      check($sformatf("wrap%0d.ia", b), 64'(InstExMemAddress), 64'((8 * b) % 512));
    end
    src_valid = 0;
    check("wrap.id1",    64'(InstExMemData1), 64'h140);
    check("wrap.id2",    64'(InstExMemData2), 64'd64);
    check("wrap.commit", 64'(src_ready),      64'd0);
    check("wrap.busy",   64'(busy),           64'd1);
    step();
    step();
    check("wrap.done",   64'(done),           64'd1);

    // reset asserted in the middle of LOAD_DATA
    start = 1; inst_beats = 1; data_beats = 2; run_limit = 0;
    step();
    start = 0; src_valid = 1; src_data = A;
    step();
    src_data = B;
    step();
    check("mid.da",  64'(DataExMemAddress), 64'd0);
    check("mid.dd1", 64'(DataExMemData1),   64'h44444444);
    check("mid.rdy", 64'(src_ready),        64'd1);
    #2 reset = 1'b0;
    #1 check_idle("rst_async");
    step();
    check_idle("rst_held");
    reset = 1'b1;
    src_valid = 1; src_data = C;
    step();
    check_idle("post_rst");
    src_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
